// File: rtl/i2c_register_target_pkg.sv
// Shared types for the I2C register target: clock/reset record and FSM state encoding.
package i2c_register_target_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_register_target_line_filter.sv
// 2-FF synchroniser plus glitch filter for one open-drain bus line; resets to idle-high.
// Latency: 2 sync clocks + GLITCH_CYCLES stable clocks; no backpressure.
module i2c_line_filter #(
  parameter int GLITCH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = $clog2(GLITCH_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      stable_cnt <= '0;
      line_filt  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_raw};
      // Any return to the current filtered level restarts the stability count.
      if (sync_q[1] == line_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(GLITCH_CYCLES - 1)) begin
        stable_cnt <= '0;
        line_filt  <= sync_q[1];
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a byte register file through an auto-incrementing register pointer.
// Latency: bus events act 2 + GLITCH_CYCLES + 1 clocks after the wire; no clock stretching, no backpressure.
module i2c_register_target
  import i2c_register_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS   = 7'h50,
  parameter int         GLITCH_CYCLES = 3
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        Scl_i,
  input  logic        Sda_i,
  output logic        SdaDrvLow_o,
  output logic        Busy_o,
  output logic        WrStrobe_o,
  output logic [7:0]  WrAddr_ob8,
  output logic [7:0]  WrData_ob8,
  output logic        RdStrobe_o,
  output logic [7:0]  RdAddr_ob8,
  input  logic [7:0]  RdData_ib8,
  output i2c_state_t  State_o,
  output logic [7:0]  AddressReceived_ob8,
  output logic [7:0]  RegisterAddressReceived_ob8
);

  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  logic scl_f, sda_f, scl_q, sda_q;
  logic start, stop, scl_rise, scl_fall;

  i2c_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filter (
    .clk(clk), .rst(rst), .line_raw(Scl_i), .line_filt(scl_f)
  );
  i2c_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filter (
    .clk(clk), .rst(rst), .line_raw(Sda_i), .line_filt(sda_f)
  );

  assign start    = scl_q & scl_f & sda_q & ~sda_f;
  assign stop     = scl_q & scl_f & ~sda_q & sda_f;
  assign scl_rise = ~scl_q & scl_f;
  assign scl_fall = scl_q & ~scl_f;

  i2c_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
  logic [7:0] addr_rcv_q, addr_rcv_d, reg_rcv_q, reg_rcv_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
  logic       sda_low_q, sda_low_d, busy_q, busy_d, load_pend_q, load_pend_d;
  logic [7:0] rx_byte;
  logic       load_now;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    addr_rcv_d  = addr_rcv_q;
    reg_rcv_d   = reg_rcv_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bit_cnt_d   = bit_cnt_q;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    load_pend_d = load_pend_q;
    rx_byte     = {shift_q[6:0], sda_f};
    load_now    = 1'b0;

    if (start) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      sda_low_d   = 1'b0;
      busy_d      = 1'b1;
      load_pend_d = 1'b0;
    end else if (stop) begin
      state_d     = IDLE;
      sda_low_d   = 1'b0;
      busy_d      = 1'b0;
      load_pend_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WRITE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                addr_rcv_d = rx_byte;
                state_d    = (rx_byte[7:1] == I2C_ADDRESS) ? ADDR_ACK : IGNORE;
              end else if (state_q == REG) begin
                reg_rcv_d = rx_byte;
                ptr_d     = rx_byte;
                state_d   = REG_ACK;
              end else begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + 8'd1;
                state_d   = WRITE_ACK;
              end
            end
          end
        end
        ADDR_ACK, REG_ACK, WRITE_ACK: begin
          // First fall starts driving the ACK, second fall ends the slot.
          if (scl_fall) begin
            sda_low_d = ~sda_low_q;
            if (sda_low_q) begin
              bit_cnt_d = '0;
              if (state_q != ADDR_ACK) begin
                state_d = WRITE;
              end else if (addr_rcv_q[0]) begin
                state_d  = READ;
                load_now = 1'b1;
              end else begin
                state_d = REG;
              end
            end
          end
        end
        READ: begin
          if (scl_fall && load_pend_q) begin
            load_now = 1'b1;
          end else if (scl_fall) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_low_d = ~shift_q[6];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = READ_ACK;
          end
        end
        READ_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_f) begin
              state_d = IGNORE;
            end else begin
              state_d     = READ;
              load_pend_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Fetch the next read byte and present its MSB on the same SCL fall.
    if (load_now) begin
      shift_d     = RdData_ib8;
      sda_low_d   = ~RdData_ib8[7];
      rd_stb_d    = 1'b1;
      ptr_d       = ptr_q + 8'd1;
      bit_cnt_d   = '0;
      load_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      ptr_q       <= '0;
      addr_rcv_q  <= '0;
      reg_rcv_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bit_cnt_q   <= '0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      load_pend_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      addr_rcv_q  <= addr_rcv_d;
      reg_rcv_q   <= reg_rcv_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      load_pend_q <= load_pend_d;
      scl_q       <= scl_f;
      sda_q       <= sda_f;
    end
  end

  assign SdaDrvLow_o                 = sda_low_q;
  assign Busy_o                      = busy_q;
  assign WrStrobe_o                  = wr_stb_q;
  assign WrAddr_ob8                  = wr_addr_q;
  assign WrData_ob8                  = wr_data_q;
  assign RdStrobe_o                  = rd_stb_q;
  assign RdAddr_ob8                  = ptr_q;
  assign State_o                     = state_q;
  assign AddressReceived_ob8         = addr_rcv_q;
  assign RegisterAddressReceived_ob8 = reg_rcv_q;

endmodule

// File: doc/i2c_register_target.md
I2C_REGISTER_TARGET -- requirements
Module: i2c_register_target

Interface
REQ-001 SHALL have parameter I2C_ADDRESS, default 7'h50: own 7-bit target address.
REQ-002 SHALL have parameter GLITCH_CYCLES, default 3: clocks a filtered line must hold stable before accepting a change.
REQ-003 SHALL have one clock and one reset, both carried by the clock/reset record ClkRs_ix (ckrs_t) and listed here first:
ClkRs_ix.clk  input  1  system clock.
ClkRs_ix.reset  input  1  reset, asynchronous, active-high.
REQ-004 Remaining ports:
Scl_i  input  1  raw SCL from the bus wire.
Sda_i  input  1  raw SDA from the bus wire.
SdaDrvLow_o  output  1  1 = pull SDA low; 0 = release. The wrapper drives 'z when released.
Busy_o  output  1  high between accepted START and STOP.
WrStrobe_o  output  1  one-cycle write pulse.
WrAddr_ob8  output  8  write register address.
WrData_ob8  output  8  write data.
RdStrobe_o  output  1  one-cycle read-consume pulse.
RdAddr_ob8  output  8  current register pointer, continuously driven.
RdData_ib8  input  8  register contents at RdAddr_ob8, combinational from the register file.
State_o  output  i2c_state_t  FSM state, for debug.
AddressReceived_ob8  output  8  last full address byte received.
RegisterAddressReceived_ob8  output  8  last register-address byte received.

Function
REQ-005 SHALL pass Scl_i and Sda_i through a 2-FF synchroniser, then a filter; the filtered value SHALL change only after the input has been stable for GLITCH_CYCLES clocks.
REQ-006 SHALL detect these events on filtered lines:
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- SCL rising edge and SCL falling edge.
REQ-007 SHALL use FSM states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-008 SHALL handle START and STOP from any state:
- START (including repeated START) → ADDR, bit counter cleared, SDA released.
- STOP → IDLE, SDA released.
REQ-009 SHALL sample incoming bits on SCL rising edge, MSB first, and SHALL change SdaDrvLow_o only on SCL falling edges.
REQ-010 SHALL load AddressReceived_ob8 on the 8th address bit.
- Address match: → ADDR_ACK, SDA low from the next SCL fall to the following SCL fall.
- Mismatch: → IGNORE, no ACK.
REQ-011 After ADDR_ACK, the R/W bit SHALL select the next state: 0 → REG, 1 → READ.
REQ-012 In REG, the 8th bit SHALL:
- load RegisterAddressReceived_ob8 and the register pointer;
- ACK via REG_ACK, then → WRITE.
REQ-013 In WRITE, on each 8th bit:
- WrStrobe_o SHALL pulse for one cycle, with WrAddr_ob8 = pointer and WrData_ob8 = byte;
- the pointer SHALL increment;
- the byte SHALL be ACKed via WRITE_ACK, then → WRITE.
REQ-014 In READ, on the SCL fall that ends the preceding ACK:
- the shift register SHALL load RdData_ib8;
- RdStrobe_o SHALL pulse for one cycle;
- the pointer SHALL increment;
- bits SHALL be driven MSB first (SdaDrvLow_o = ~bit).
REQ-015 In READ_ACK, SDA SHALL be released and the master's bit sampled on SCL rise:
- 0 (ACK) → READ, next byte;
- 1 (NACK) → IGNORE.
REQ-016 The pointer SHALL wrap 8'hFF → 8'h00, SHALL persist across repeated START and STOP, and SHALL be cleared only by reset.
REQ-017 Busy_o SHALL set on START and clear on STOP.
REQ-018 A START and an SCL edge detected in the same cycle SHALL resolve in favour of START.

Reset
REQ-019 Reset SHALL asynchronously force:
- SdaDrvLow_o = 0, Busy_o = 0, both strobes = 0;
- State_o = IDLE;
- all address, data and pointer registers = 8'h00;
- filter outputs = 1 (idle bus).
REQ-020 Reset mid-transfer SHALL release SDA immediately. After release from reset, the block SHALL ignore the bus until the next START.

Structure
REQ-021 i2c_state_t SHALL reside in the shared types package. No other package additions.
REQ-022 Synchroniser plus glitch filter SHALL be one sub-module, i2c_line_filter, instantiated once for SCL and once for SDA.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → all ACKed; WrStrobe twice, (0x10, 0x5A) then (0x11, 0xC3); Busy low after STOP.
- Read with repeated START: START, 0xA0, 0x20, rSTART, 0xA1, master ACK then NACK; RdData = addr + 1 → bytes 0x21, 0x22 returned; two RdStrobe pulses; pointer 0x22.
- Address mismatch: START, 0xB0 → no ACK, State IGNORE, AddressReceived 0xB0; no strobes until STOP.
- Wrap-around: pointer 0xFF, write 0x01, 0x02 → WrAddr 0xFF then 0x00.
- Glitch rejection: 2-clock SDA pulse while SCL high → no START or STOP, state unchanged.
- Reset mid-read while driving SDA low → SdaDrvLow_o = 0 and State IDLE in the same cycle reset asserts.
